// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
package rv32i_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned PKT_W = XLEN * 2 + 1;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FAULT = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // One decode-bound fetch packet
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } fetch_pkt_t;

endpackage

// File: rtl/fifo_rv32i.sv
// Synchronous FIFO with registered storage, synchronous clear and occupancy count.
module fifo_rv32i #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_clear,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push at full is accepted only when the head leaves in the same cycle
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_rv32i.sv
// RV32I fetch stage: credit-limited imem requests, in-order response buffering,
// misaligned-PC fault packets and flush/drain handling toward decode.
module fetch_rv32i
    import rv32i_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            pc_advance_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [XLEN-1:0] id_instr_o,
    output logic            id_fault_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [OUT_W-1:0] r_outstanding;
    logic [OUT_W-1:0] w_outstanding_nxt;
    logic [OUT_W-1:0] r_discard;
    logic [OUT_W-1:0] w_discard_nxt;

    logic [CNT_W-1:0] w_fifo_count;
    logic [CNT_W-1:0] w_pcq_count;
    logic [XLEN-1:0]  w_pcq_head;
    fetch_pkt_t       w_fifo_wdata;
    fetch_pkt_t       w_fifo_head;

    logic w_aligned;
    logic w_room;
    logic w_req;
    logic w_gnt;
    logic w_rvalid;
    logic w_keep_rdata;
    logic w_fault_push;
    logic w_fifo_push;
    logic w_fifo_pop;
    logic w_id_valid;

    // Every grant reserves a buffer slot so a returning word always has room
    assign w_aligned = (pc_i[1:0] == 2'b00);
    assign w_room    = (SUM_W'(w_fifo_count) + SUM_W'(r_outstanding)) < SUM_W'(FIFO_DEPTH);
    assign w_req     = rst && (r_state == ST_RUN) && !flush_i && w_aligned
                       && (r_outstanding < OUT_W'(MAX_OUTSTANDING)) && w_room;
    assign w_gnt     = w_req && imem_gnt_i;
    assign w_rvalid  = imem_rvalid_i && (r_outstanding != '0);

    assign w_keep_rdata = w_rvalid && !flush_i && (r_discard == '0);
    // Fault packet waits for in-flight words so the two pushes never collide
    assign w_fault_push = (r_state == ST_RUN) && !flush_i && !w_aligned
                          && (r_outstanding == '0) && (w_fifo_count != CNT_W'(FIFO_DEPTH));
    assign w_fifo_push  = w_keep_rdata || w_fault_push;
    assign w_id_valid   = (w_fifo_count != '0);
    assign w_fifo_pop   = w_id_valid && id_ready_i && !flush_i;

    always_comb begin
        w_fifo_wdata = '0;
        if (w_fault_push) begin
            w_fifo_wdata.pc    = pc_i;
            w_fifo_wdata.instr = NOP_INSTR;
            w_fifo_wdata.fault = 1'b1;
        end else begin
            w_fifo_wdata.pc    = w_pcq_head;
            w_fifo_wdata.instr = imem_rdata_i;
            w_fifo_wdata.fault = 1'b0;
        end
    end

    fifo_rv32i #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_buf (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_fifo_push),
        .i_data  (w_fifo_wdata),
        .i_pop   (w_fifo_pop),
        .i_clear (flush_i),
        .o_data  (w_fifo_head),
        .o_count (w_fifo_count)
    );

    // PCs of granted requests, matched in order with rvalid responses
    fifo_rv32i #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_gnt),
        .i_data  (pc_i),
        .i_pop   (w_rvalid),
        .i_clear (1'b0),
        .o_data  (w_pcq_head),
        .o_count (w_pcq_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_RUN;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_outstanding <= w_outstanding_nxt;
            r_discard     <= w_discard_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_outstanding_nxt = r_outstanding;
        w_discard_nxt     = r_discard;

        case ({w_gnt, w_rvalid})
            2'b10:   w_outstanding_nxt = r_outstanding + OUT_W'(1);
            2'b01:   w_outstanding_nxt = r_outstanding - OUT_W'(1);
            default: w_outstanding_nxt = r_outstanding;
        endcase

        if (flush_i) begin
            // Everything still in flight after this cycle must be dropped
            w_discard_nxt = r_outstanding - OUT_W'(w_rvalid);
            w_state_nxt   = (w_discard_nxt != '0) ? ST_DRAIN : ST_RUN;
        end else begin
            if (w_rvalid && (r_discard != '0)) begin
                w_discard_nxt = r_discard - OUT_W'(1);
            end
            case (r_state)
                ST_RUN:   if (w_fault_push) w_state_nxt = ST_FAULT;
                ST_FAULT: w_state_nxt = ST_FAULT;
                ST_DRAIN: if (w_discard_nxt == '0) w_state_nxt = ST_RUN;
                default:  w_state_nxt = ST_RUN;
            endcase
        end
    end

    assign pc_advance_o = w_gnt;
    assign imem_req_o   = w_req;
    assign imem_addr_o  = rst ? pc_i : '0;
    assign id_valid_o   = w_id_valid;
    assign id_pc_o      = w_id_valid ? w_fifo_head.pc : '0;
    assign id_instr_o   = w_id_valid ? w_fifo_head.instr : '0;
    assign id_fault_o   = w_id_valid && w_fifo_head.fault;

    a_rvalid_protocol: assert property (@(posedge clk) disable iff (!rst)
        !(imem_rvalid_i && (r_outstanding == '0)));
    a_pcq_tracks_outstanding: assert property (@(posedge clk) disable iff (!rst)
        w_pcq_count == CNT_W'(r_outstanding));

endmodule

// File: tb/tb_fetch_rv32i.sv
// Directed scenarios plus random traffic against a queue-based model of the fetch stage.
module tb_fetch_rv32i;
    import rv32i_pkg::*;

    localparam int DEPTH = 2;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_i = '0;
    logic        flush_i = 1'b0;
    logic        pc_advance_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        id_valid_o;
    logic        id_ready_i = 1'b0;
    logic [31:0] id_pc_o;
    logic [31:0] id_instr_o;
    logic        id_fault_o;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] pc; bit drop; } flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } pkt_t;

    flight_t     inflight[$];
    pkt_t        outq[$];
    bit          faulted = 1'b0;
    logic [31:0] pc = '0;

    always #5 clk = ~clk;

    fetch_rv32i #(.FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_i          (pc_i),
        .flush_i       (flush_i),
        .pc_advance_o  (pc_advance_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .id_valid_o    (id_valid_o),
        .id_ready_i    (id_ready_i),
        .id_pc_o       (id_pc_o),
        .id_instr_o    (id_instr_o),
        .id_fault_o    (id_fault_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    function automatic bit draining();
        foreach (inflight[i]) if (inflight[i].drop) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks();
        chk("rst_req",     32'(imem_req_o),   32'd0);
        chk("rst_adv",     32'(pc_advance_o), 32'd0);
        chk("rst_addr",    imem_addr_o,       32'd0);
        chk("rst_valid",   32'(id_valid_o),   32'd0);
        chk("rst_pc",      id_pc_o,           32'd0);
        chk("rst_instr",   id_instr_o,        32'd0);
        chk("rst_fault",   32'(id_fault_o),   32'd0);
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model
    task automatic tick(input bit gnt, input bit rv, input bit rdy, input bit fl,
                        input logic [31:0] tgt);
        bit      do_rv, run, exp_req, exp_fault;
        flight_t e;
        @(negedge clk);
        do_rv         = rv && (inflight.size() > 0);
        pc_i          = pc;
        imem_gnt_i    = gnt;
        id_ready_i    = rdy;
        flush_i       = fl;
        imem_rvalid_i = do_rv;
        imem_rdata_i  = do_rv ? mem_word(inflight[0].pc) : $urandom;
        #1;
        run       = !faulted && !draining();
        exp_req   = run && !fl && (pc[1:0] == 2'b00) && (inflight.size() < MAXO)
                    && (outq.size() + inflight.size() < DEPTH);
        exp_fault = run && !fl && (pc[1:0] != 2'b00) && (inflight.size() == 0)
                    && (outq.size() < DEPTH);
        chk("imem_req",   32'(imem_req_o),   32'(exp_req));
        chk("pc_advance", 32'(pc_advance_o), 32'(exp_req && gnt));
        chk("imem_addr",  imem_addr_o,       pc);
        chk("id_valid",   32'(id_valid_o),   32'(outq.size() != 0));
        if (outq.size() != 0) begin
            chk("id_pc",    id_pc_o,         outq[0].pc);
            chk("id_instr", id_instr_o,      outq[0].instr);
            chk("id_fault", 32'(id_fault_o), 32'(outq[0].fault));
        end
        if (do_rv) e = inflight.pop_front();
        if ((outq.size() != 0) && rdy && !fl) void'(outq.pop_front());
        if (do_rv && !fl && !e.drop) outq.push_back('{e.pc, mem_word(e.pc), 1'b0});
        if (exp_fault) begin
            outq.push_back('{pc, NOP_INSTR, 1'b1});
            faulted = 1'b1;
        end
        if (exp_req && gnt) begin
            inflight.push_back('{pc, 1'b0});
            pc = pc + 32'd4;
        end
        if (fl) begin
            outq.delete();
            foreach (inflight[i]) inflight[i].drop = 1'b1;
            faulted = 1'b0;
            pc      = tgt;
        end
    endtask

    task automatic redirect(input logic [31:0] tgt);
        tick(1'b0, 1'b1, 1'b1, 1'b1, tgt);
        for (int i = 0; i < 4; i++) begin
            if (inflight.size() != 0) tick(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] tgt;

        repeat (2) @(negedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        rst = 1'b1;

        // Zero-wait memory, decode always ready
        pc = 32'h0;
        repeat (8) tick(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

        // Decode stall: credits run out, head held stable, then drains in order
        redirect(32'h0);
        repeat (5) tick(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        repeat (6) tick(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

        // Two in flight, flush, late responses dropped, resume at 0x100
        redirect(32'h10);
        repeat (2) tick(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
        repeat (2) tick(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        repeat (4) tick(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

        // Misaligned PC: fault packet, no requests until redirect to 0x200
        redirect(32'h102);
        repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        repeat (3) tick(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        redirect(32'h200);
        repeat (4) tick(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

        // Flush coincident with rvalid and a decode pop
        redirect(32'h300);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 32'h400);
        repeat (4) tick(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

        // Reset mid-stream with two requests outstanding
        redirect(32'h500);
        repeat (2) tick(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        imem_gnt_i = 1'b0;
        flush_i    = 1'b0;
        rst        = 1'b0;
        #1;
        reset_checks();
        inflight.delete();
        outq.delete();
        faulted = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        imem_rvalid_i = 1'b0;
        #1;
        reset_checks();
        rst = 1'b1;
        repeat (4) tick(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

        // Random traffic
        repeat (1500) begin
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
